// File: rtl/m_ifetch_pkg.sv
// Shared constants for the instruction-fetch front end.
package m_ifetch_pkg;
    localparam logic [31:0] HALT_INSN   = 32'h000f0033;
    localparam int          IMEM_ADDR_W = 12;
endpackage

// File: rtl/m_ifq.sv
// Prefetch FIFO of {pc, ir} entries; head visible the cycle after push, no bypass.
// Push is dropped when full unless a pop frees the slot the same cycle; flush wins over push.
module m_ifq #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop) & ~flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/m_ifetch.sv
// Fetch PC, imem request tracking and halt logic; issue->w_ir_valid takes 2 cycles.
// Issue is credit-gated on queue space (plus any same-cycle pop); redirect flushes and refetches.
module m_ifetch
    import m_ifetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = IMEM_ADDR_W,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    output logic [ADDR_W-1:0] w_imem_addr,
    input  logic [31:0]       w_imem_dout,
    input  logic              w_redirect,
    input  logic [31:0]       w_redirect_pc,
    input  logic              w_ir_ready,
    output logic              w_ir_valid,
    output logic [31:0]       w_ir,
    output logic [31:0]       w_ir_pc,
    output logic              w_halted
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   r_fpc;
    logic [31:0]   r_req_pc;
    logic          r_req_v;
    logic          r_halted;

    logic [CW-1:0] q_count;
    logic          q_empty;
    logic          q_full;
    logic [63:0]   q_head;

    logic          pop;
    logic          push;
    logic          ret_halt;
    logic          halt_block;
    logic          credit;
    logic          issue;
    logic [31:0]   issue_pc;

    assign pop        = w_ir_valid & w_ir_ready;
    assign push       = r_req_v & ~w_redirect;
    assign ret_halt   = r_req_v & (w_imem_dout == HALT_INSN);
    assign halt_block = r_halted | ret_halt;
    // Room exists unless the queue plus the in-flight word would reach DEPTH.
    assign credit     = pop | (~q_full & ~(r_req_v & (q_count == CW'(DEPTH - 1))));
    assign issue      = w_redirect | (~halt_block & credit);
    assign issue_pc   = w_redirect ? (w_redirect_pc & ~32'd3) : r_fpc;
    assign w_imem_addr = issue_pc[ADDR_W+1:2];

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_fpc    <= RESET_PC;
            r_req_v  <= 1'b0;
            r_req_pc <= '0;
            r_halted <= 1'b0;
        end else begin
            r_req_v <= issue;
            if (issue) begin
                r_req_pc <= issue_pc;
                r_fpc    <= issue_pc + 32'd4;
            end
            if (w_redirect)    r_halted <= 1'b0;
            else if (ret_halt) r_halted <= 1'b1;
        end
    end

    m_ifq #(.DEPTH(DEPTH), .W(64)) u_ifq (
        .clk      (w_clk),
        .rst_n    (w_rst_n),
        .push     (push),
        .push_dat ({r_req_pc, w_imem_dout}),
        .pop      (pop),
        .flush    (w_redirect),
        .head     (q_head),
        .count    (q_count),
        .empty    (q_empty),
        .full     (q_full)
    );

    assign w_ir_valid = ~q_empty;
    assign w_ir       = w_ir_valid ? q_head[31:0]  : 32'h0;
    assign w_ir_pc    = w_ir_valid ? q_head[63:32] : 32'h0;
    assign w_halted   = r_halted;
endmodule

// File: tb/tb_m_ifetch.sv
// Scoreboarded bench for m_ifetch with a synchronous imem model.
module tb_m_ifetch;
    localparam logic [31:0] HALT = 32'h000f0033;

    logic        w_clk = 1'b0;
    logic        w_rst_n = 1'b1;
    logic [11:0] w_imem_addr;
    logic [31:0] w_imem_dout = 32'h0;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = 32'h0;
    logic        w_ir_ready = 1'b0;
    logic        w_ir_valid;
    logic [31:0] w_ir;
    logic [31:0] w_ir_pc;
    logic        w_halted;

    logic [31:0] imem [4096];
    logic [63:0] expq [$];
    logic [63:0] mon_e;
    int          ncmp = 0;
    int          nfail = 0;
    int          n;

    m_ifetch #(.DEPTH(4), .ADDR_W(12), .RESET_PC(32'h0)) dut (
        .w_clk         (w_clk),
        .w_rst_n       (w_rst_n),
        .w_imem_addr   (w_imem_addr),
        .w_imem_dout   (w_imem_dout),
        .w_redirect    (w_redirect),
        .w_redirect_pc (w_redirect_pc),
        .w_ir_ready    (w_ir_ready),
        .w_ir_valid    (w_ir_valid),
        .w_ir          (w_ir),
        .w_ir_pc       (w_ir_pc),
        .w_halted      (w_halted)
    );

    always #5 w_clk = ~w_clk;

    always @(posedge w_clk) w_imem_dout <= imem[w_imem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        ncmp++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic fill(input int halt_idx);
        for (int i = 0; i < 64; i++) imem[i] = 32'h1000_0000 + i;
        imem[halt_idx] = HALT;
    endtask

    task automatic expect_word(input int idx);
        expq.push_back({32'(idx * 4), imem[idx]});
    endtask

    task automatic drain(input int max);
        int k;
        k = 0;
        while (expq.size() != 0 && k < max) begin
            tick();
            k++;
        end
        chk("drain_left", 32'(expq.size()), 32'h0);
        expq.delete();
    endtask

    // Monitor: every accepted instruction is checked against the head of the scoreboard.
    always @(negedge w_clk) begin
        if (w_rst_n) begin
            if (w_ir_valid && w_ir_ready) begin
                if (expq.size() == 0) begin
                    ncmp++;
                    nfail++;
                    $display("FAIL unexpected_delivery: got pc %h ir %h, expected none", w_ir_pc, w_ir);
                end else begin
                    mon_e = expq.pop_front();
                    chk("deliver_pc", w_ir_pc, mon_e[63:32]);
                    chk("deliver_ir", w_ir, mon_e[31:0]);
                end
            end else if (!w_ir_valid) begin
                chk("idle_zero", w_ir | w_ir_pc, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4096; i++) imem[i] = 32'h0;

        // Reset state
        fill(20);
        #1 w_rst_n = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(w_ir_valid), 32'h0);
        chk("rst_ir", w_ir, 32'h0);
        chk("rst_pc", w_ir_pc, 32'h0);
        chk("rst_halted", 32'(w_halted), 32'h0);
        chk("rst_addr", 32'(w_imem_addr), 32'h0);

        // Streaming, backpressure, halt at word 20
        for (int i = 0; i <= 20; i++) expect_word(i);
        w_ir_ready = 1'b1;
        w_rst_n = 1'b1;
        tick();
        chk("a_addr1", 32'(w_imem_addr), 32'h1);
        tick();
        chk("a_first_valid", 32'(w_ir_valid), 32'h1);
        chk("a_first_ir", w_ir, 32'h1000_0000);
        chk("a_first_pc", w_ir_pc, 32'h0);
        repeat (4) tick();
        w_ir_ready = 1'b0;
        repeat (10) tick();
        chk("a_stall_addr", 32'(w_imem_addr), 32'h8);
        chk("a_stall_head", w_ir_pc, 32'h10);
        w_ir_ready = 1'b1;
        n = 0;
        while (expq.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk("a_drain_cycles", 32'(n), 32'd17);
        expq.delete();
        repeat (3) tick();
        chk("a_halted", 32'(w_halted), 32'h1);
        chk("a_halt_valid", 32'(w_ir_valid), 32'h0);
        chk("a_halt_addr", 32'(w_imem_addr), 32'd21);

        // Halt at word 3, then redirect out of halt
        w_rst_n = 1'b0;
        fill(3);
        imem[11] = HALT;
        tick();
        for (int i = 0; i <= 3; i++) expect_word(i);
        w_rst_n = 1'b1;
        repeat (10) tick();
        chk("b_halted", 32'(w_halted), 32'h1);
        chk("b_halt_valid", 32'(w_ir_valid), 32'h0);
        chk("b_halt_addr", 32'(w_imem_addr), 32'h4);
        chk("b_drained", 32'(expq.size()), 32'h0);
        for (int i = 8; i <= 11; i++) expect_word(i);
        w_redirect = 1'b1;
        w_redirect_pc = 32'h22;
        #1;
        chk("b_redir_addr", 32'(w_imem_addr), 32'h8);
        tick();
        w_redirect = 1'b0;
        chk("b_unhalted", 32'(w_halted), 32'h0);
        drain(20);
        repeat (2) tick();
        chk("b_rehalted", 32'(w_halted), 32'h1);

        // Redirect while full, popping pc 4 in the same cycle
        w_rst_n = 1'b0;
        w_ir_ready = 1'b0;
        fill(18);
        tick();
        expect_word(0);
        expect_word(1);
        for (int i = 16; i <= 18; i++) expect_word(i);
        w_rst_n = 1'b1;
        repeat (5) tick();
        w_ir_ready = 1'b1;
        tick();
        w_ir_ready = 1'b0;
        tick();
        chk("c_head_pc", w_ir_pc, 32'h4);
        w_ir_ready = 1'b1;
        w_redirect = 1'b1;
        w_redirect_pc = 32'h40;
        #1;
        chk("c_redir_addr", 32'(w_imem_addr), 32'h10);
        tick();
        w_redirect = 1'b0;
        chk("c_flushed", 32'(w_ir_valid), 32'h0);
        tick();
        chk("c_tgt_valid", 32'(w_ir_valid), 32'h1);
        chk("c_tgt_pc", w_ir_pc, 32'h40);
        chk("c_tgt_ir", w_ir, 32'h1000_0010);
        drain(20);

        // Asynchronous reset mid-stream
        w_rst_n = 1'b0;
        fill(6);
        tick();
        for (int i = 0; i <= 2; i++) expect_word(i);
        w_rst_n = 1'b1;
        repeat (5) tick();
        #2;
        w_rst_n = 1'b0;
        #1;
        chk("d_rst_valid", 32'(w_ir_valid), 32'h0);
        chk("d_rst_ir", w_ir, 32'h0);
        chk("d_rst_pc", w_ir_pc, 32'h0);
        chk("d_rst_halted", 32'(w_halted), 32'h0);
        chk("d_rst_addr", 32'(w_imem_addr), 32'h0);
        chk("d_pre_rst_count", 32'(expq.size()), 32'h0);
        expq.delete();
        tick();
        for (int i = 0; i <= 6; i++) expect_word(i);
        w_rst_n = 1'b1;
        drain(30);
        repeat (2) tick();
        chk("d_halted", 32'(w_halted), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/m_ifetch.md
Name: m_ifetch

Overview:
- Instruction-fetch front end that sits directly upstream of the processor's decode/execute datapath.
- Generates the fetch PC and drives the word address of the synchronous instruction memory (one-cycle read latency).
- Tags each returned word with its PC and buffers it in a small prefetch queue.
- Hands instructions to decode over a valid/ready handshake; supports taken-branch redirects and stops fetching at the halt instruction.

Parameters:
DEPTH, 4, prefetch queue entries (power of two, ≥2)
ADDR_W, 12, instruction-memory word-address width
RESET_PC, 32'h0, fetch PC after reset

Ports:
w_clk  in  1  clock, all state updates on posedge
w_rst_n  in  1  asynchronous active-low reset
w_imem_addr  out  ADDR_W  word address to synchronous imem; data returns next cycle
w_imem_dout  in  32  imem read data for the previous cycle's address
w_redirect  in  1  taken branch/jump from execute; flush and refetch
w_redirect_pc  in  32  redirect target byte address
w_ir_ready  in  1  decode accepts head instruction this cycle
w_ir_valid  out  1  queue head valid
w_ir  out  32  head instruction word, 0 when not valid
w_ir_pc  out  32  head instruction byte PC, 0 when not valid
w_halted  out  1  halt word (32'h000f0033) fetched, issue stopped

Behaviour:
- Reset (async, while w_rst_n=0): r_fpc=RESET_PC, queue count=0, r_req_v=0, r_req_pc=0, r_halted=0. Outputs: w_ir_valid=0, w_ir=0, w_ir_pc=0, w_halted=0, w_imem_addr=RESET_PC[ADDR_W+1:2]. Assertion mid-stream discards everything immediately.
- Pop: w_ir_valid & w_ir_ready removes the head.
- Issue condition: !halt_block & (count + r_req_v < DEPTH | pop).
  - halt_block = r_halted | (r_req_v & w_imem_dout==HALT).
  - Redirect ignores halt_block but still requires credit (credit is always available after a flush).
- Address select: w_imem_addr = w_redirect ? w_redirect_pc[ADDR_W+1:2] : r_fpc[ADDR_W+1:2]. The address is always driven; only the issue flag records a real request.
- On issue: r_req_v<=1, r_req_pc<=issued PC, r_fpc<=issued PC+4. Otherwise r_req_v<=0 and r_fpc holds.
- Return: when r_req_v=1 and there is no redirect this cycle, {r_req_pc, w_imem_dout} is pushed into the queue. If the word is HALT, r_halted<=1.
- Latency and throughput:
  - Issue at cycle N → data at cycle N+1 → w_ir_valid at cycle N+2 (queue is registered, no bypass).
  - Sustained throughput is 1 instruction/cycle while decode is ready.
- Redirect (priority over all else):
  - A pop in the same cycle is honoured (the branch itself was consumed).
  - Queue is flushed (count=0) and the in-flight return is discarded.
  - r_halted<=0.
  - The target is issued that same cycle; w_redirect_pc[1:0] are ignored (treated as 0).
- Queue boundaries:
  - Full with no pop → no issue.
  - Full with pop → issue allowed; the return lands next cycle into the freed slot. Push and pop in the same cycle keep count unchanged.
  - Empty → w_ir_valid=0.
  - Pointers wrap modulo DEPTH; never overflow or underflow.
- Arithmetic: r_fpc+4 wraps modulo 2^32. Memory addressing wraps within 2^ADDR_W words.
- Halt: the HALT word itself is enqueued and delivered to decode. No later PC is enqueued. w_halted = r_halted.

Decomposition:
- Shared package holds the constants HALT_INSN=32'h000f0033 and IMEM_ADDR_W=12.
- One sub-module, m_ifq: a DEPTH-entry synchronous FIFO of 64-bit {pc, ir} entries.
  - Controls: push, pop, flush.
  - Status: count, empty, full.
  - Async active-low reset.
- m_ifetch keeps the PC, the request tracker and the halt logic.

Test Plan:
- Reset release, imem[i]=32'h1000_0000+i, w_ir_ready=1 → w_imem_addr 0,1,2,… one per cycle; w_ir_valid first high 2 cycles after first issue with w_ir=32'h1000_0000, w_ir_pc=0, then pc 4, 8, … every cycle.
- Hold w_ir_ready=0 for 10 cycles → exactly 4 entries queued, no further issue recorded. Release ready → pcs continue 0,4,8,…, with no gap larger than 1 cycle and no duplicate or missing pc.
- Queue holding pcs 8,0xC,0x10; pulse w_redirect with target 0x40 and pop pc 4 → pc 4 consumed, queued entries discarded, w_imem_addr=0x10 same cycle, next w_ir_pc=0x40 with w_ir=imem[16] 2 cycles later.
- imem[3]=32'h000f0033 → delivered pcs 0,4,8,0xC; w_halted=1; no entry with pc 0x10 ever appears; w_ir_valid stays 0 afterwards.
- While halted, redirect to 0x20 → w_halted=0 the next cycle and fetch resumes at pc 0x20, 0x24, ….
- Assert w_rst_n=0 mid-stream, asynchronously between edges → w_ir_valid, w_ir, w_ir_pc and w_halted go to 0 immediately. After release, fetch restarts at RESET_PC.
